// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: 24-bit unsigned shift-add multiply / restoring divide sequencer.
// Drives an external ALU one add/subtract per cycle.
module alu_seq_muldiv #(
    parameter int WIDTH  = 24,
    parameter int ITER_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             func_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_by_zero_o,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    output logic             alu_b_negate_o,
    output logic [1:0]       alu_op_o,
    input  logic [WIDTH-1:0] alu_result_i,
    input  logic             alu_carry_out_i,
    input  logic             alu_zero_i,
    input  logic             alu_overflow_i
);
    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2;
    logic [1:0]        state_q, state_d;
    logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d, m_q, m_d;
    logic [ITER_W-1:0] cnt_q, cnt_d;
    logic              func_q, func_d, dbz_q, dbz_d;
    logic              run, accept, dbz_in, q_bit;
    logic [WIDTH-1:0]  rem_sh;
    logic              unused_alu_flags;
    assign unused_alu_flags = alu_zero_i ^ alu_overflow_i;
    assign run    = state_q == S_RUN;
    assign accept = start_i && !run;
    assign dbz_in = func_i && op_b_i == '0;
    // Quotient bit: a bit shifted out of the remainder always means R' exceeds the divisor.
    assign rem_sh = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
    assign q_bit  = hi_q[WIDTH-1] | alu_carry_out_i;
    assign busy_o         = run;
    assign done_o         = state_q == S_DONE;
    assign hi_o           = hi_q;
    assign lo_o           = lo_q;
    assign div_by_zero_o  = dbz_q;
    assign alu_a_o        = !run ? '0 : func_q ? rem_sh : hi_q;
    assign alu_b_o        = (run && (func_q || lo_q[0])) ? m_q : '0;
    assign alu_b_negate_o = run && func_q;
    assign alu_op_o       = run ? 2'b10 : 2'b00;
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        func_d  = func_q;
        dbz_d   = dbz_q;
        if (accept) begin
            func_d  = func_i;
            m_d     = func_i ? op_b_i : op_a_i;
            cnt_d   = '0;
            dbz_d   = dbz_in;
            hi_d    = dbz_in ? op_a_i : '0;
            lo_d    = dbz_in ? '1 : func_i ? op_a_i : op_b_i;
            state_d = dbz_in ? S_DONE : S_RUN;
        end else if (run) begin
            cnt_d   = cnt_q + 1'b1;
            hi_d    = func_q ? (q_bit ? alu_result_i : rem_sh) : {alu_carry_out_i, alu_result_i[WIDTH-1:1]};
            lo_d    = func_q ? {lo_q[WIDTH-2:0], q_bit} : {alu_result_i[0], lo_q[WIDTH-1:1]};
            state_d = cnt_q == ITER_W'(WIDTH - 1) ? S_DONE : S_RUN;
        end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            func_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            func_q  <= func_d;
            dbz_q   <= dbz_d;
        end
    end
endmodule

// File: tb/tb_alu_seq_muldiv.sv
// tb_alu_seq_muldiv: directed bench for the multiply/divide sequencer with a behavioural ALU.
module tb_alu_seq_muldiv;
    logic        clk = 0, rst = 1, start = 0, func = 0;
    logic [23:0] op_a = 0, op_b = 0;
    logic        busy, done, dbz, alu_neg;
    logic [23:0] hi, lo, alu_a, alu_b, alu_res;
    logic [1:0]  alu_op;
    logic        alu_co, alu_z, alu_ov;
    logic [24:0] sum;
    int          n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    alu_seq_muldiv dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .func_i(func),
        .op_a_i(op_a), .op_b_i(op_b), .busy_o(busy), .done_o(done),
        .hi_o(hi), .lo_o(lo), .div_by_zero_o(dbz),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_b_negate_o(alu_neg), .alu_op_o(alu_op),
        .alu_result_i(alu_res), .alu_carry_out_i(alu_co),
        .alu_zero_i(alu_z), .alu_overflow_i(alu_ov)
    );

    // Behavioural ALU: 00 AND, 01 OR, 10 ADD/SUB with BNegate as carry-in.
    always_comb begin
        sum     = {1'b0, alu_a} + {1'b0, alu_neg ? ~alu_b : alu_b} + {24'd0, alu_neg};
        alu_res = alu_op == 2'b00 ? (alu_a & alu_b) : alu_op == 2'b01 ? (alu_a | alu_b) : sum[23:0];
        alu_co  = alu_op == 2'b10 ? sum[24] : 1'b0;
        alu_z   = alu_res == 24'd0;
        alu_ov  = alu_op == 2'b10 && (alu_a[23] == (alu_neg ? ~alu_b[23] : alu_b[23])) && (alu_res[23] != alu_a[23]);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic f, input logic [23:0] a, input logic [23:0] b);
        func = f; op_a = a; op_b = b; start = 1;
        step();
        start = 0;
    endtask

    // lat: 1-based cycle index after accept at which Done is seen (-1 on timeout).
    task automatic wait_done(output int lat, output int busy_n);
        lat = -1; busy_n = 0;
        for (int i = 1; i <= 40; i++) begin
            if (done) begin lat = i; break; end
            if (busy) busy_n++;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1;
        step(); step();
        n_cmp++;
        if ({busy, done, dbz, hi, lo} !== 51'd0) begin
            n_bad++; $display("FAIL reset_outputs: got busy=%b done=%b dbz=%b hi=%h lo=%h, need all 0", busy, done, dbz, hi, lo);
        end
        n_cmp++;
        if ({alu_a, alu_b, alu_neg, alu_op} !== 51'd0) begin
            n_bad++; $display("FAIL reset_alu: got a=%h b=%h neg=%b op=%b, need all 0", alu_a, alu_b, alu_neg, alu_op);
        end
        rst = 0;
        step();
    endtask

    task automatic test_mul_small();
        int lat, bn;
        start_op(0, 24'h000003, 24'h000005);
        n_cmp++;
        if (alu_a !== 24'h0 || alu_b !== 24'h3 || alu_neg !== 1'b0 || alu_op !== 2'b10) begin
            n_bad++; $display("FAIL mul_first_iter_alu: got a=%h b=%h neg=%b op=%b, need 000000 000003 0 10", alu_a, alu_b, alu_neg, alu_op);
        end
        wait_done(lat, bn);
        n_cmp++;
        if (lat !== 25 || bn !== 24 || busy !== 1'b0) begin
            n_bad++; $display("FAIL mul_small_timing: got done_at=%0d busy_cycles=%0d busy_at_done=%b, need 25 24 0", lat, bn, busy);
        end
        n_cmp++;
        if (hi !== 24'h0 || lo !== 24'h00000F || dbz !== 1'b0) begin
            n_bad++; $display("FAIL mul_small_result: got hi=%h lo=%h dbz=%b, need 000000 00000f 0", hi, lo, dbz);
        end
        step();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || hi !== 24'h0 || lo !== 24'h00000F || alu_op !== 2'b00) begin
            n_bad++; $display("FAIL mul_small_hold: got done=%b busy=%b hi=%h lo=%h op=%b, need 0 0 000000 00000f 00", done, busy, hi, lo, alu_op);
        end
    endtask

    task automatic test_mul_max();
        int lat, bn;
        start_op(0, 24'hFFFFFF, 24'hFFFFFF);
        wait_done(lat, bn);
        n_cmp++;
        if (lat !== 25 || bn !== 24 || hi !== 24'hFFFFFE || lo !== 24'h000001) begin
            n_bad++; $display("FAIL mul_max: got done_at=%0d busy=%0d hi=%h lo=%h, need 25 24 fffffe 000001", lat, bn, hi, lo);
        end
        step();
    endtask

    task automatic test_divide();
        int lat, bn;
        start_op(1, 24'd100, 24'd7);
        n_cmp++;
        if (alu_a !== 24'h0 || alu_b !== 24'h7 || alu_neg !== 1'b1 || alu_op !== 2'b10) begin
            n_bad++; $display("FAIL div_first_iter_alu: got a=%h b=%h neg=%b op=%b, need 000000 000007 1 10", alu_a, alu_b, alu_neg, alu_op);
        end
        wait_done(lat, bn);
        n_cmp++;
        if (lat !== 25 || bn !== 24 || lo !== 24'h00000E || hi !== 24'h000002 || dbz !== 1'b0) begin
            n_bad++; $display("FAIL div_100_7: got done_at=%0d busy=%0d hi=%h lo=%h dbz=%b, need 25 24 000002 00000e 0", lat, bn, hi, lo, dbz);
        end
        step();
        start_op(1, 24'hFFFFFF, 24'h000001);
        wait_done(lat, bn);
        n_cmp++;
        if (lat !== 25 || lo !== 24'hFFFFFF || hi !== 24'h0) begin
            n_bad++; $display("FAIL div_max_by_1: got done_at=%0d hi=%h lo=%h, need 25 000000 ffffff", lat, hi, lo);
        end
        step();
        start_op(1, 24'h800000, 24'hC00000);
        wait_done(lat, bn);
        n_cmp++;
        if (lat !== 25 || lo !== 24'h0 || hi !== 24'h800000) begin
            n_bad++; $display("FAIL div_sbit: got done_at=%0d hi=%h lo=%h, need 25 800000 000000", lat, hi, lo);
        end
        step();
    endtask

    task automatic test_div_by_zero();
        int lat, bn;
        start_op(1, 24'h001234, 24'h0);
        wait_done(lat, bn);
        n_cmp++;
        if (lat !== 1 || bn !== 0 || dbz !== 1'b1 || lo !== 24'hFFFFFF || hi !== 24'h001234) begin
            n_bad++; $display("FAIL div_zero: got done_at=%0d busy=%0d dbz=%b hi=%h lo=%h, need 1 0 1 001234 ffffff", lat, bn, dbz, hi, lo);
        end
        step();
        n_cmp++;
        if (dbz !== 1'b1 || done !== 1'b0) begin
            n_bad++; $display("FAIL div_zero_hold: got dbz=%b done=%b, need 1 0", dbz, done);
        end
        start_op(0, 24'h000003, 24'h000005);
        n_cmp++;
        if (dbz !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL dbz_clear: got dbz=%b busy=%b, need 0 1", dbz, busy);
        end
        wait_done(lat, bn);
        n_cmp++;
        if (lat !== 25 || lo !== 24'h00000F || hi !== 24'h0 || dbz !== 1'b0) begin
            n_bad++; $display("FAIL mul_after_dbz: got done_at=%0d hi=%h lo=%h dbz=%b, need 25 000000 00000f 0", lat, hi, lo, dbz);
        end
        step();
    endtask

    task automatic test_start_in_run();
        int lat, bn;
        start_op(1, 24'd100, 24'd7);
        for (int i = 1; i < 10; i++) step();
        func = 0; op_a = 24'h000055; op_b = 24'h000002; start = 1;
        step();
        start = 0;
        wait_done(lat, bn);
        n_cmp++;
        if (lat !== 15 || lo !== 24'h00000E || hi !== 24'h000002) begin
            n_bad++; $display("FAIL start_in_run: got done_at=%0d hi=%h lo=%h, need 15 000002 00000e", lat, hi, lo);
        end
        step();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL start_in_run_idle: got busy=%b done=%b, need 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bn;
        start_op(1, 24'h800000, 24'hC00000);
        wait_done(lat, bn);
        start_op(0, 24'h000010, 24'h000100);
        n_cmp++;
        if (lat !== 25 || busy !== 1'b1 || done !== 1'b0) begin
            n_bad++; $display("FAIL b2b_accept: got first_done_at=%0d busy=%b done=%b, need 25 1 0", lat, busy, done);
        end
        wait_done(lat, bn);
        n_cmp++;
        if (lat !== 25 || bn !== 24 || hi !== 24'h0 || lo !== 24'h001000) begin
            n_bad++; $display("FAIL b2b_result: got done_at=%0d busy=%0d hi=%h lo=%h, need 25 24 000000 001000", lat, bn, hi, lo);
        end
        step();
    endtask

    task automatic test_reset_mid_run();
        int lat, bn, seen;
        start_op(0, 24'hFFFFFF, 24'hFFFFFF);
        for (int i = 1; i < 12; i++) step();
        rst = 1;
        step();
        rst = 0;
        n_cmp++;
        if ({busy, done, dbz, hi, lo, alu_a, alu_b, alu_neg, alu_op} !== 102'd0) begin
            n_bad++; $display("FAIL reset_mid_run: got busy=%b done=%b hi=%h lo=%h a=%h b=%h neg=%b op=%b, need all 0", busy, done, hi, lo, alu_a, alu_b, alu_neg, alu_op);
        end
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (done || busy) seen++;
            step();
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++; $display("FAIL reset_no_done: got %0d busy/done cycles, need 0", seen);
        end
        start_op(0, 24'h000123, 24'h000456);
        wait_done(lat, bn);
        n_cmp++;
        if (lat !== 25 || bn !== 24 || hi !== 24'h0 || lo !== 24'h04EDC2) begin
            n_bad++; $display("FAIL mul_after_reset: got done_at=%0d busy=%0d hi=%h lo=%h, need 25 24 000000 04edc2", lat, bn, hi, lo);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_mul_small();
        test_mul_max();
        test_divide();
        test_div_by_zero();
        test_start_in_run();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
